// File: rtl/fft_top_cmul_rnd_sat_if.sv
// Sample/result bundle for the FFT twiddle complex multiplier.
// The butterfly side drives as master; the multiplier sits on the slave modport.
interface fft_top_cmul_rnd_sat_if #(
   parameter int A_W   = 24,
   parameter int B_W   = 16,
   parameter int OUT_W = 24
);
   logic                    ce;
   logic                    in_valid;
   logic signed [A_W-1:0]   a_re;
   logic signed [A_W-1:0]   a_im;
   logic signed [B_W-1:0]   b_re;
   logic signed [B_W-1:0]   b_im;
   logic                    conj_b;
   logic                    ovf_clr;
   logic                    out_valid;
   logic signed [OUT_W-1:0] p_re;
   logic signed [OUT_W-1:0] p_im;
   logic                    ovf;

   modport master (output ce, in_valid, a_re, a_im, b_re, b_im, conj_b, ovf_clr,
                   input  out_valid, p_re, p_im, ovf);
   modport slave  (input  ce, in_valid, a_re, a_im, b_re, b_im, conj_b, ovf_clr,
                   output out_valid, p_re, p_im, ovf);
endinterface

// File: rtl/fft_top_cmul_rnd_sat.sv
// Pipelined complex multiply p = a*b (or a*conj(b)) with round, shift and saturate.
// Define FFT_CMUL_CONVERGENT_EN for round-half-to-even instead of round-half-up.
module fft_top_cmul_rnd_sat #(
   parameter int A_W        = 24,
   parameter int B_W        = 16,
   parameter int OUT_W      = 24,
   parameter int FRAC_SHIFT = 15,
   parameter int NUM_STAGE  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   fft_top_cmul_rnd_sat_if.slave  bus
);
   localparam int P_W = A_W + B_W;
   localparam int S_W = P_W + 1;
   localparam int R_W = S_W + 1;
   localparam int ND  = NUM_STAGE - 4;

   localparam logic signed [R_W-1:0] HALF = R_W'(1) <<< (FRAC_SHIFT - 1);
   localparam logic signed [R_W-1:0] SMAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [R_W-1:0] SMIN = ~SMAX;
`ifdef FFT_CMUL_CONVERGENT_EN
   localparam logic [R_W-1:0] MASK = {{(R_W-FRAC_SHIFT){1'b0}}, {FRAC_SHIFT{1'b1}}};
`endif

   // MSB of the return value flags saturation; the rest is the clipped result
   function automatic logic [OUT_W:0] rnd_sat(input logic signed [S_W-1:0] x);
      logic signed [R_W-1:0] xe, r;
      xe = x;
      r  = (xe + HALF) >>> FRAC_SHIFT;
`ifdef FFT_CMUL_CONVERGENT_EN
      if (((xe & MASK) == HALF) && r[0]) r = r - R_W'(1);
`endif
      if (r > SMAX)      rnd_sat = {1'b1, SMAX[OUT_W-1:0]};
      else if (r < SMIN) rnd_sat = {1'b1, SMIN[OUT_W-1:0]};
      else               rnd_sat = {1'b0, r[OUT_W-1:0]};
   endfunction

   logic signed [A_W-1:0]   ar1, ai1;
   logic signed [B_W-1:0]   br1, bi1;
   logic                    cj1, cj2;
   logic signed [P_W-1:0]   rr2, ii2, ri2, ir2;
   logic signed [S_W-1:0]   sr3, si3;
   logic signed [OUT_W-1:0] pr_d [0:ND];
   logic signed [OUT_W-1:0] pi_d [0:ND];
   logic [NUM_STAGE:1]      vld_pipe;
   logic                    ovf_q;
   logic [OUT_W:0]          rs_re, rs_im;
   logic                    sat4;

   assign rs_re = rnd_sat(sr3);
   assign rs_im = rnd_sat(si3);
   assign sat4  = (rs_re[OUT_W] | rs_im[OUT_W]) & vld_pipe[3];

   always_ff @(posedge clk) begin
      if (!reset) begin
         ar1 <= '0; ai1 <= '0; br1 <= '0; bi1 <= '0;
         cj1 <= 1'b0; cj2 <= 1'b0;
         rr2 <= '0; ii2 <= '0; ri2 <= '0; ir2 <= '0;
         sr3 <= '0; si3 <= '0;
         for (int i = 0; i <= ND; i++) begin
            pr_d[i] <= '0;
            pi_d[i] <= '0;
         end
         vld_pipe <= '0;
         ovf_q    <= 1'b0;
      end else if (bus.ce) begin
         ar1 <= bus.a_re; ai1 <= bus.a_im;
         br1 <= bus.b_re; bi1 <= bus.b_im;
         cj1 <= bus.conj_b;
         vld_pipe <= {vld_pipe[NUM_STAGE-1:1], bus.in_valid};
         // products fit P_W exactly, so sign-extended operands give the full result
         rr2 <= P_W'(ar1) * P_W'(br1);
         ii2 <= P_W'(ai1) * P_W'(bi1);
         ri2 <= P_W'(ar1) * P_W'(bi1);
         ir2 <= P_W'(ai1) * P_W'(br1);
         cj2 <= cj1;
         sr3 <= cj2 ? S_W'(rr2) + S_W'(ii2) : S_W'(rr2) - S_W'(ii2);
         si3 <= cj2 ? S_W'(ir2) - S_W'(ri2) : S_W'(ir2) + S_W'(ri2);
         pr_d[0] <= rs_re[OUT_W-1:0];
         pi_d[0] <= rs_im[OUT_W-1:0];
         for (int i = 1; i <= ND; i++) begin
            pr_d[i] <= pr_d[i-1];
            pi_d[i] <= pi_d[i-1];
         end
         // a new saturation outranks a same-cycle clear
         ovf_q <= sat4 | (ovf_q & ~bus.ovf_clr);
      end
   end

   assign bus.out_valid = vld_pipe[NUM_STAGE];
   assign bus.p_re      = pr_d[ND];
   assign bus.p_im      = pi_d[ND];
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_top_cmul_rnd_sat.sv
// Scoreboarded bench for fft_top_cmul_rnd_sat: a NUM_STAGE=4 and a NUM_STAGE=6
// instance share one stimulus stream; each has its own expected-result queue.
module tb_fft_top_cmul_rnd_sat;
   localparam int A_W = 24, B_W = 16, OUT_W = 24, FS = 15;
`ifdef FFT_CMUL_CONVERGENT_EN
   localparam longint RND1 = 0;
`else
   localparam longint RND1 = 1;
`endif

   typedef struct { longint re; longint im; longint due; } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0, checks = 0;
   bit   mon_en = 1'b0;
   longint cnt = 0;
   int   repoch = 0;
   exp_t q [2][$];
   exp_t cur [2];
   bit   curv [2];
   longint last_cnt [2];
   int   last_ep [2];

   always #5 clk = ~clk;

   fft_top_cmul_rnd_sat_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) i4 ();
   fft_top_cmul_rnd_sat_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) i6 ();

   assign i6.ce = i4.ce;           assign i6.in_valid = i4.in_valid;
   assign i6.a_re = i4.a_re;       assign i6.a_im = i4.a_im;
   assign i6.b_re = i4.b_re;       assign i6.b_im = i4.b_im;
   assign i6.conj_b = i4.conj_b;   assign i6.ovf_clr = i4.ovf_clr;

   fft_top_cmul_rnd_sat #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .FRAC_SHIFT(FS), .NUM_STAGE(4))
      u4 (.clk(clk), .reset(reset), .bus(i4));
   fft_top_cmul_rnd_sat #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .FRAC_SHIFT(FS), .NUM_STAGE(6))
      u6 (.clk(clk), .reset(reset), .bus(i6));

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint rs(input longint x);
      longint y;
      y = (x + (longint'(1) <<< (FS-1))) >>> FS;
`ifdef FFT_CMUL_CONVERGENT_EN
      if ((x & ((longint'(1) <<< FS) - 1)) == (longint'(1) <<< (FS-1)) && y[0]) y = y - 1;
`endif
      if (y > 8388607) y = 8388607;
      if (y < -8388608) y = -8388608;
      return y;
   endfunction

   function automatic exp_t mk(input longint ar, ai, br, bi, input bit cj, input longint due);
      exp_t e;
      longint rr, ii, ri, ir;
      rr = ar * br; ii = ai * bi; ri = ar * bi; ir = ai * br;
      e.re  = rs(cj ? rr + ii : rr - ii);
      e.im  = rs(cj ? ir - ri : ir + ri);
      e.due = due;
      return e;
   endfunction

   // capture side: expected results are due NUM_STAGE-1 ce-edges after this one
   always @(posedge clk) begin
      if (!reset) begin
         q[0].delete();
         q[1].delete();
         repoch <= repoch + 1;
      end else if (i4.ce) begin
         cnt <= cnt + 1;
         if (i4.in_valid) begin
            q[0].push_back(mk(i4.a_re, i4.a_im, i4.b_re, i4.b_im, i4.conj_b, cnt + 4));
            q[1].push_back(mk(i4.a_re, i4.a_im, i4.b_re, i4.b_im, i4.conj_b, cnt + 6));
         end
      end
   end

   // output side: a result is held (and rechecked) until the next ce-edge
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            automatic exp_t e = cur[d];
            automatic bit v = curv[d];
            automatic logic ov = (d == 0) ? i4.out_valid : i6.out_valid;
            automatic logic signed [OUT_W-1:0] pr = (d == 0) ? i4.p_re : i6.p_re;
            automatic logic signed [OUT_W-1:0] pi = (d == 0) ? i4.p_im : i6.p_im;
            if (repoch != last_ep[d]) v = 1'b0;
            else if (cnt != last_cnt[d]) begin
               v = 1'b0;
               if (q[d].size() > 0 && q[d][0].due == cnt) begin
                  e = q[d].pop_front();
                  v = 1'b1;
               end
            end
            check(d == 0 ? "sb4_valid" : "sb6_valid", ov, v);
            if (v) begin
               check(d == 0 ? "sb4_re" : "sb6_re", pr, e.re);
               check(d == 0 ? "sb4_im" : "sb6_im", pi, e.im);
            end
            cur[d]      <= e;
            curv[d]     <= v;
            last_ep[d]  <= repoch;
            last_cnt[d] <= cnt;
         end
      end
   end

   task automatic put(input bit v, input longint ar, ai, br, bi, input bit cj);
      @(negedge clk);
      i4.ce = 1'b1; i4.in_valid = v;
      i4.a_re = A_W'(ar); i4.a_im = A_W'(ai);
      i4.b_re = B_W'(br); i4.b_im = B_W'(bi);
      i4.conj_b = cj;
   endtask

   task automatic idle();
      put(1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_vld4"}, i4.out_valid, 0); check({tag, "_vld6"}, i6.out_valid, 0);
      check({tag, "_re4"}, i4.p_re, 0);       check({tag, "_im4"}, i4.p_im, 0);
      check({tag, "_re6"}, i6.p_re, 0);       check({tag, "_ovf4"}, i4.ovf, 0);
      check({tag, "_ovf6"}, i6.ovf, 0);
   endtask

   initial begin
      logic signed [A_W-1:0] r24a, r24b;
      logic signed [B_W-1:0] r16a, r16b;
      reset = 1'b0;
      i4.ce = 1'b1; i4.in_valid = 1'b0; i4.conj_b = 1'b0; i4.ovf_clr = 1'b0;
      i4.a_re = '0; i4.a_im = '0; i4.b_re = '0; i4.b_im = '0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      reset = 1'b1;
      mon_en = 1'b1;

      // scale by 0.5, exact latency
      put(1, 1000, -2000, 16384, 0, 0);
      idle();
      repeat (2) @(negedge clk);
      check("t1_vld_early", i4.out_valid, 0);
      @(negedge clk);
      check("t1_vld", i4.out_valid, 1);
      check("t1_re", i4.p_re, 500);
      check("t1_im", i4.p_im, -1000);
      check("t1_ovf", i4.ovf, 0);
      @(negedge clk);
      check("t1_vld_after", i4.out_valid, 0);

      // rotation by j, with and without conjugate, back to back
      put(1, 0, 32768, 0, 32767, 0);
      put(1, 0, 32768, 0, 32767, 1);
      idle();
      repeat (2) @(negedge clk);
      check("t2_re_rot", i4.p_re, -32767);
      check("t2_im_rot", i4.p_im, 0);
      @(negedge clk);
      check("t2_vld_conj", i4.out_valid, 1);
      check("t2_re_conj", i4.p_re, 32767);

      // saturation and sticky overflow
      put(1, 8388607, 8388607, -32768, -32768, 0);
      put(1, 1000, -2000, 16384, 0, 0);
      idle();
      repeat (2) @(negedge clk);
      check("t3_sat_re", i4.p_re, 0);
      check("t3_sat_im", i4.p_im, -8388608);
      check("t3_ovf_set", i4.ovf, 1);
      @(negedge clk);
      check("t3_ovf_sticky", i4.ovf, 1);
      repeat (2) @(negedge clk);
      i4.ovf_clr = 1'b1;
      @(negedge clk);
      i4.ovf_clr = 1'b0;
      check("t3_ovf_clr", i4.ovf, 0);
      put(1, 8388607, 8388607, -32768, -32768, 0);
      idle();
      repeat (2) @(negedge clk);
      check("t3_ovf_pre", i4.ovf, 0);
      i4.ovf_clr = 1'b1;
      @(negedge clk);
      i4.ovf_clr = 1'b0;
      check("t3_ovf_set_wins", i4.ovf, 1);

      // rounding ties and near-ties
      put(1, 1, 0, 16384, 0, 0);
      put(1, 3, 0, 16384, 0, 0);
      put(1, -1, 0, 16384, 0, 0);
      idle();
      @(negedge clk);
      check("t4_rnd_p1", i4.p_re, RND1);
      @(negedge clk);
      check("t4_rnd_p3", i4.p_re, 2);
      @(negedge clk);
      check("t4_rnd_m1", i4.p_re, 0);

      // ovf_clr is ignored while ce is low
      @(negedge clk);
      i4.ce = 1'b0; i4.ovf_clr = 1'b1;
      @(negedge clk);
      check("t5_ovf_ce0", i4.ovf, 1);
      i4.ce = 1'b1;
      @(negedge clk);
      i4.ovf_clr = 1'b0;
      check("t5_ovf_clr2", i4.ovf, 0);

      // six samples with a three-cycle stall after the second
      for (int i = 0; i < 6; i++) begin
         if (i == 4) put(1, -8388608, -8388608, -32768, -32768, 0);
         else put(1, i * 1000 + 7, -i * 333, 23170, -23170, i[0]);
         if (i == 1) repeat (3) begin
            @(negedge clk);
            i4.ce = 1'b0;
         end
      end
      idle();
      repeat (8) @(negedge clk);
      check("t5_ovf_extreme", i4.ovf, 1);

      // reset with samples in flight on the deep instance
      put(1, 111, 222, 16384, 16384, 0);
      put(1, 333, 444, 16384, 16384, 1);
      put(1, 555, 666, 16384, 16384, 0);
      @(negedge clk);
      i4.in_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk_reset("t6");
      put(1, 2000, 4000, 16384, 0, 0);
      idle();
      repeat (4) @(negedge clk);
      check("t6_vld6_early", i6.out_valid, 0);
      @(negedge clk);
      check("t6_vld6", i6.out_valid, 1);
      check("t6_re6", i6.p_re, 1000);
      check("t6_im6", i6.p_im, 2000);

      // random stream with random ce
      for (int i = 0; i < 80; i++) begin
         r24a = A_W'($urandom); r24b = A_W'($urandom);
         r16a = B_W'($urandom); r16b = B_W'($urandom);
         put(1'($urandom_range(0, 1)), r24a, r24b, r16a, r16b, 1'($urandom_range(0, 1)));
         i4.ce = ($urandom_range(0, 3) != 0);
      end
      idle();
      repeat (10) @(negedge clk);
      check("drain4", q[0].size(), 0);
      check("drain6", q[1].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
